jtag_dm_ctrl: RTL

Debug-module control front end: terminates DMI read/write requests arriving from the JTAG DTM side and drives the hart-facing run-control handshake (haltreq, resumereq, clear_resumeack) into the debug memory block. Implements dmcontrol, dmstatus and the abstract data registers, and reports hart state back to the debugger. Sits between the DTM and the debug memory inside the debug subsystem.

---
 rtl/jtag_dm_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/jtag_dm_ctrl.sv
// rtl/jtag_dm_ctrl.sv - DMI front end for dmcontrol/dmstatus/data regs with hart run-control levels
// Optional feature: define JTAG_DM_NDMRESET_EN to make dmcontrol.ndmreset writable and drive ndmreset_o.
module jtag_dm_ctrl #(
  parameter int DATA_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic [1:0]  dmi_resp_err_o,
  output logic        haltreq_o,
  output logic        resumereq_o,
  output logic        clear_resumeack_o,
  output logic        ndmreset_o,
  output logic        dmactive_o,
  input  logic        halted_i,
  input  logic        resumeack_i,
  input  logic        cmdbusy_i
);

  localparam logic [6:0] ADDR_DATA0     = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        dmactive_q, haltreq_q, resumereq_q, ndmreset_q, clr_ack_q;
  logic [31:0] data_q [DATA_COUNT];
  logic [31:0] resp_data_q;
  logic [1:0]  resp_err_q;
  logic [6:0]  data_off;
  logic        is_data;
  logic [31:0] data_sel;
  logic [31:0] dmstatus;
  logic [31:0] rd_data;
  logic [1:0]  rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    dmi_req_ready_o  = 1'b0;
    dmi_resp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmi_req_ready_o = 1'b1;
        if (dmi_req_valid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        dmi_resp_valid_o = 1'b1;
        if (dmi_resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = (state_q == ST_IDLE) && dmi_req_valid_i;
  assign data_off = dmi_req_addr_i - ADDR_DATA0;
  assign is_data  = (dmi_req_addr_i >= ADDR_DATA0) && (data_off < 7'(DATA_COUNT));

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < DATA_COUNT; i++)
      if (data_off == 7'(i)) data_sel = data_q[i];
  end

  assign dmstatus = {14'b0, resumeack_i, resumeack_i, 4'b0, !halted_i, !halted_i,
                     halted_i, halted_i, 1'b1, 3'b0, 4'd2};

  // Response is computed combinationally from the live request and captured on accept.
  always_comb begin
    rd_data = '0;
    rd_err  = 2'd0;
    case (dmi_req_op_i)
      OP_READ: begin
        if (dmi_req_addr_i == ADDR_DMCONTROL)
          rd_data = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
        else if (dmi_req_addr_i == ADDR_DMSTATUS)
          rd_data = dmstatus;
        else if (is_data && dmactive_q) begin
          rd_data = data_sel;
          rd_err  = cmdbusy_i ? 2'd3 : 2'd0;
        end
      end
      OP_WRITE: if (is_data && dmactive_q && cmdbusy_i) rd_err = 2'd3;
      OP_RSVD:  rd_err = 2'd2;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      ndmreset_q  <= 1'b0;
      clr_ack_q   <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 2'd0;
      for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
    end else begin
      clr_ack_q <= 1'b0;
      if (resumereq_q && resumeack_i) resumereq_q <= 1'b0;
      if (accept) begin
        resp_data_q <= rd_data;
        resp_err_q  <= rd_err;
        if (dmi_req_op_i == OP_WRITE && dmi_req_addr_i == ADDR_DMCONTROL) begin
          if (!dmi_req_data_i[0]) begin
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            ndmreset_q  <= 1'b0;
            for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
          end else begin
            dmactive_q <= 1'b1;
            haltreq_q  <= dmi_req_data_i[31];
`ifdef JTAG_DM_NDMRESET_EN
            ndmreset_q <= dmi_req_data_i[1];
`endif
            // A simultaneous halt request wins over resume.
            if (dmi_req_data_i[30] && !dmi_req_data_i[31]) begin
              resumereq_q <= 1'b1;
              clr_ack_q   <= 1'b1;
            end
          end
        end else if (dmi_req_op_i == OP_WRITE && is_data && dmactive_q && !cmdbusy_i) begin
          for (int i = 0; i < DATA_COUNT; i++)
            if (data_off == 7'(i)) data_q[i] <= dmi_req_data_i;
        end
      end
    end
  end

  assign dmi_resp_data_o   = resp_data_q;
  assign dmi_resp_err_o    = resp_err_q;
  assign haltreq_o         = haltreq_q;
  assign resumereq_o       = resumereq_q;
  assign clear_resumeack_o = clr_ack_q;
  assign dmactive_o        = dmactive_q;
`ifdef JTAG_DM_NDMRESET_EN
  assign ndmreset_o        = ndmreset_q;
`else
  assign ndmreset_o        = 1'b0;
`endif

endmodule
